// File: rtl/lloyds_pkg.sv
// Shared defaults, FSM encoding and load-length helper for the Lloyd's block loader.
package lloyds_pkg;

  localparam int unsigned N_DEF      = 128;
  localparam int unsigned D_DEF      = 3;
  localparam int unsigned B_DEF      = 16;
  localparam int unsigned DATA_W_DEF = 32;

  localparam int unsigned BLK_WORDS  = B_DEF * D_DEF;
  localparam int unsigned MAX_ADDR   = (N_DEF - B_DEF) * D_DEF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  // Words to pull for a block starting at word offset addr; the last block may be short.
  function automatic logic [31:0] load_len(input logic [31:0] addr,
                                           input int unsigned n,
                                           input int unsigned d,
                                           input int unsigned b);
    logic [31:0] full_end;
    logic [31:0] tail_start;
    full_end   = 32'(n * d);
    tail_start = 32'((n - b) * d);
    if (addr <= tail_start) begin
      return 32'(b * d);
    end else if (addr < full_end) begin
      return full_end - addr;
    end else begin
      return '0;
    end
  endfunction

endpackage

// File: rtl/lloyds_block_buf.sv
// Simple dual-port block buffer: one write port, one registered read port (read-before-write).
module lloyds_block_buf #(
  parameter int unsigned DEPTH  = 48,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only the output register is reset; array contents persist across blocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/lloyds_block_loader.sv
// ap_ctrl_hs block loader: pulls one block of points from an ap_fifo stream into a local buffer
// and produces a 32-bit word checksum of the block.
module lloyds_block_loader
  import lloyds_pkg::*;
#(
  parameter int unsigned N      = N_DEF,
  parameter int unsigned D      = D_DEF,
  parameter int unsigned B      = B_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  localparam int unsigned AW    = $clog2(B * D)
) (
  input  logic              clk_in1,
  input  logic              reset,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [31:0]       block_address,
  input  logic [DATA_W-1:0] data_points_in_dout,
  input  logic              data_points_in_empty_n,
  output logic              data_points_in_read,
  input  logic [AW-1:0]     buf_rd_addr,
  output logic [DATA_W-1:0] buf_rd_data,
  output logic [31:0]       word_sum,
  output logic              word_sum_ap_vld
);

  localparam int unsigned BLK = B * D;
  localparam int unsigned CW  = $clog2(BLK + 1);

  state_t          state;
  logic [CW-1:0]   wcnt;
  logic [CW-1:0]   len_q;
  logic [CW-1:0]   len_next;
  logic [31:0]     sum;
  logic [31:0]     sum_next;
  logic            last_word;
  logic [AW-1:0]   wr_addr;

  assign len_next  = CW'(load_len(block_address, N, D, B));
  assign sum_next  = sum + 32'(data_points_in_dout);
  assign wr_addr   = AW'(wcnt);

  assign data_points_in_read = (state == S_LOAD) && data_points_in_empty_n &&
                               (wcnt < len_q) && !reset;
  assign last_word = data_points_in_read && (wcnt == len_q - CW'(1));

  always_ff @(posedge clk_in1) begin
    if (reset) begin
      state           <= S_IDLE;
      ap_idle         <= 1'b1;
      ap_done         <= 1'b0;
      ap_ready        <= 1'b0;
      word_sum_ap_vld <= 1'b0;
      word_sum        <= '0;
      sum             <= '0;
      wcnt            <= '0;
      len_q           <= '0;
    end else begin
      ap_done         <= 1'b0;
      ap_ready        <= 1'b0;
      word_sum_ap_vld <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (ap_start) begin
            len_q   <= len_next;
            wcnt    <= '0;
            sum     <= '0;
            ap_idle <= 1'b0;
            // An empty block skips LOAD so done lands one cycle after start.
            if (len_next == '0) begin
              state           <= S_DONE;
              ap_done         <= 1'b1;
              ap_ready        <= 1'b1;
              word_sum_ap_vld <= 1'b1;
              word_sum        <= '0;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (data_points_in_read) begin
            wcnt <= wcnt + CW'(1);
            sum  <= sum_next;
          end
          if (last_word) begin
            state           <= S_DONE;
            ap_done         <= 1'b1;
            ap_ready        <= 1'b1;
            word_sum_ap_vld <= 1'b1;
            word_sum        <= sum_next;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          ap_idle <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          ap_idle <= 1'b1;
        end
      endcase
    end
  end

  lloyds_block_buf #(
    .DEPTH (BLK),
    .DATA_W(DATA_W),
    .AW    (AW)
  ) u_buf (
    .clk    (clk_in1),
    .reset  (reset),
    .wr_en  (data_points_in_read),
    .wr_addr(wr_addr),
    .wr_data(data_points_in_dout),
    .rd_addr(buf_rd_addr),
    .rd_data(buf_rd_data)
  );

endmodule

// File: tb/tb_lloyds_block_loader.sv
// Bench for lloyds_block_loader: FIFO model, start-time scoreboard, vector table and corner sequences.
module tb_lloyds_block_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_done, ap_idle, ap_ready;
  logic [31:0] block_address = '0;
  logic [31:0] data_points_in_dout = '0;
  logic        data_points_in_empty_n = 1'b0;
  logic        data_points_in_read;
  logic [5:0]  buf_rd_addr = '0;
  logic [31:0] buf_rd_data;
  logic [31:0] word_sum;
  logic        word_sum_ap_vld;

  always #5 clk = ~clk;

  lloyds_block_loader #(
    .N(128), .D(3), .B(16), .DATA_W(32)
  ) dut (
    .clk_in1               (clk),
    .reset                 (reset),
    .ap_start              (ap_start),
    .ap_done               (ap_done),
    .ap_idle               (ap_idle),
    .ap_ready              (ap_ready),
    .block_address         (block_address),
    .data_points_in_dout   (data_points_in_dout),
    .data_points_in_empty_n(data_points_in_empty_n),
    .data_points_in_read   (data_points_in_read),
    .buf_rd_addr           (buf_rd_addr),
    .buf_rd_data           (buf_rd_data),
    .word_sum              (word_sum),
    .word_sum_ap_vld       (word_sum_ap_vld)
  );

  typedef struct {
    logic [31:0] sum;
    int unsigned len;
    int unsigned start;
    bit          chk_lat;
    logic [31:0] w [48];
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          stall;
    logic [31:0] base;
    logic [31:0] step;
    int unsigned n_push;
    int unsigned len;
    logic [31:0] sum;
  } vec_t;

  exp_t        sb [$];
  logic [31:0] fifo_q [$];
  logic [31:0] exp_buf [48];
  vec_t        tbl [7];

  int unsigned n_checks = 0, n_pass = 0;
  int unsigned cyc = 0, rd_cnt = 0, done_cnt = 0, accept_cnt = 0;
  int unsigned last_done_cyc = 0, last_len = 0, b2b_from = 0;
  logic [31:0] last_sum = '0;
  bit alt_mode = 1'b0, gate = 1'b0, b2b_mode = 1'b0, pop_pend = 1'b0, prev_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int unsigned model_len(input logic [31:0] a);
    if (a <= 32'd336) return 48;
    else if (a < 32'd384) return 384 - a;
    else return 0;
  endfunction

  // FIFO model: pop what the DUT consumed at the last edge, present the new head.
  always @(negedge clk) begin
    if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
    gate = ~gate;
    data_points_in_dout    = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    data_points_in_empty_n = (fifo_q.size() > 0) && (!alt_mode || gate);
  end

  // Start monitor: expected result is built from the FIFO contents at acceptance.
  always @(posedge clk) begin : mon
    exp_t e;
    cyc      <= cyc + 1;
    pop_pend <= data_points_in_read;
    if (reset) begin
      sb.delete();
      rd_cnt <= 0;
    end else begin
      if (data_points_in_read) rd_cnt <= rd_cnt + 1;
      if (ap_idle && ap_start) begin
        assert (block_address % 3 == 0) else $error("block_address not a multiple of D");
        e.len = model_len(block_address);
        e.sum = '0;
        e.start = cyc;
        e.chk_lat = !alt_mode;
        for (int i = 0; i < 48; i++) e.w[i] = '0;
        for (int i = 0; i < int'(e.len); i++) begin
          e.w[i] = (i < fifo_q.size()) ? fifo_q[i] : '0;
          e.sum += e.w[i];
        end
        if (b2b_mode && accept_cnt > b2b_from) check("b2b_gap", cyc, last_done_cyc + 1);
        sb.push_back(e);
        rd_cnt     <= 0;
        accept_cnt <= accept_cnt + 1;
      end
    end
  end

  // Completion checker.
  always @(negedge clk) begin : chk
    exp_t e;
    if (!reset) begin
      check("ready_vld_with_done", {ap_ready, word_sum_ap_vld}, {ap_done, ap_done});
      if (ap_done) begin
        check("done_single_cycle", prev_done, 0);
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got ap_done=1 expected no pending block");
        end else begin
          e = sb.pop_front();
          check("word_sum", word_sum, e.sum);
          check("read_count", rd_cnt, e.len);
          if (e.chk_lat) check("done_latency", cyc - e.start, e.len + 1);
          check("idle_low_at_done", ap_idle, 0);
          for (int i = 0; i < int'(e.len); i++) exp_buf[i] = e.w[i];
        end
        last_sum      <= word_sum;
        last_len      <= rd_cnt;
        last_done_cyc <= cyc;
        done_cnt      <= done_cnt + 1;
      end
    end
    prev_done <= ap_done;
  end

  task automatic wait_done(input int unsigned target);
    int unsigned k = 0;
    while (done_cnt < target && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt < target) begin
      n_checks++;
      $display("FAIL done_timeout: got %0d completions expected %0d", done_cnt, target);
    end
  endtask

  task automatic sweep_buf();
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      buf_rd_addr = 6'(i);
      @(posedge clk);
      #1 check($sformatf("buf[%0d]", i), buf_rd_data, exp_buf[i]);
    end
  endtask

  task automatic run_vec(input vec_t t);
    int unsigned target;
    target = done_cnt + 1;
    @(negedge clk);
    for (int i = 0; i < int'(t.n_push); i++) fifo_q.push_back(t.base + 32'(i) * t.step);
    alt_mode = t.stall;
    @(negedge clk);
    check("idle_before_start", ap_idle, 1);
    block_address = t.addr;
    ap_start = 1'b1;
    @(posedge clk);
    #1 ap_start = 1'b0;
    wait_done(target);
    @(negedge clk);
    alt_mode = 1'b0;
    check("fifo_drained", fifo_q.size(), 0);
    check("vec_len", last_len, t.len);
    check("vec_sum", last_sum, t.sum);
    check("idle_after_done", ap_idle, 1);
    sweep_buf();
  endtask

  initial begin
    int unsigned k, acc0, tgt;
    vec_t rv;
    tbl[0] = '{addr: 32'd0,   stall: 1'b0, base: 32'd1,    step: 32'd1, n_push: 48, len: 48, sum: 32'd1176};
    tbl[1] = '{addr: 32'd48,  stall: 1'b1, base: 32'd100,  step: 32'd1, n_push: 48, len: 48, sum: 32'd5928};
    tbl[2] = '{addr: 32'd360, stall: 1'b0, base: 32'd1000, step: 32'd1, n_push: 24, len: 24, sum: 32'd24276};
    tbl[3] = '{addr: 32'd384, stall: 1'b0, base: 32'd0,    step: 32'd1, n_push: 0,  len: 0,  sum: 32'd0};
    tbl[4] = '{addr: 32'd336, stall: 1'b0, base: 32'd7,    step: 32'd1, n_push: 48, len: 48, sum: 32'd1464};
    tbl[5] = '{addr: 32'd339, stall: 1'b0, base: 32'd0,    step: 32'd1, n_push: 45, len: 45, sum: 32'd990};
    tbl[6] = '{addr: 32'd0,   stall: 1'b0, base: 32'hFFFF_FFFF, step: 32'd0, n_push: 48, len: 48,
               sum: 32'hFFFF_FFD0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_ap_idle", ap_idle, 1);
    check("rst_ap_done", ap_done, 0);
    check("rst_ap_ready", ap_ready, 0);
    check("rst_vld", word_sum_ap_vld, 0);
    check("rst_read", data_points_in_read, 0);
    check("rst_word_sum", word_sum, 0);
    check("rst_buf_rd_data", buf_rd_data, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 7; v++) run_vec(tbl[v]);

    // Reset after 10 accepted words, then restart from the remaining FIFO head.
    @(negedge clk);
    for (int i = 0; i < 58; i++) fifo_q.push_back(32'd500 + 32'(i));
    @(negedge clk);
    block_address = '0;
    ap_start = 1'b1;
    @(posedge clk);
    #1 ap_start = 1'b0;
    k = 0;
    while (rd_cnt < 10 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("rst_wait_10_words", rd_cnt, 10);
    reset = 1'b1;
    #1 check("midload_read_forced_low", data_points_in_read, 0);
    @(posedge clk);
    #1 check("midload_idle_next", ap_idle, 1);
    check("midload_no_done", ap_done, 0);
    @(negedge clk);
    check("midload_no_consume", fifo_q.size(), 48);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    rv = '{addr: 32'd0, stall: 1'b0, base: 32'd0, step: 32'd0, n_push: 0, len: 48, sum: 32'd25608};
    run_vec(rv);

    // ap_start held high; address changes during the first load.
    @(negedge clk);
    for (int i = 0; i < 72; i++) fifo_q.push_back(32'd2000 + 32'(i));
    b2b_from = accept_cnt;
    b2b_mode = 1'b1;
    tgt = done_cnt + 2;
    acc0 = accept_cnt;
    @(negedge clk);
    block_address = '0;
    ap_start = 1'b1;
    k = 0;
    while (accept_cnt == acc0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    while (rd_cnt < 5 && k < 50) begin
      @(negedge clk);
      k++;
    end
    block_address = 32'd360;
    k = 0;
    while (accept_cnt < acc0 + 2 && k < 300) begin
      @(negedge clk);
      k++;
    end
    ap_start = 1'b0;
    check("b2b_two_accepts", accept_cnt, acc0 + 2);
    wait_done(tgt);
    @(negedge clk);
    b2b_mode = 1'b0;
    check("b2b_second_len", last_len, 24);
    check("b2b_second_sum", last_sum, 32'd49428);
    check("b2b_fifo_drained", fifo_q.size(), 0);
    sweep_buf();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
